// File: rtl/hilo_muldiv_sequencer_if.sv
// Bus between the CPU control FSM and the HI/LO multiply/divide unit.
//   start/funct/op_a/op_b : request from control (master -> slave)
//   busy/done/hi/lo       : status and architectural HI/LO (slave -> master)
interface hilo_muldiv_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, funct, op_a, op_b, input busy, done, hi, lo);
  modport slave  (input start, funct, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Executes MTHI/MTLO in one cycle, MULT/MULTU as a 32-step shift-add and
// DIV/DIVU as a 32-step restoring divide on operand magnitudes, with a final
// sign fixup before HI/LO are committed.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of hilo_muldiv_sequencer_if (start/funct/op_a/op_b in,
//           busy/done/hi/lo out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_MUL   | one shift-add step per cycle, cnt_q 0..DATA_W-1
// S_DIV   | one restoring-divide step per cycle, cnt_q 0..DATA_W-1
// S_FIXUP | apply result signs, commit HI/LO
// S_DONE  | done pulse; a new start may be accepted here
module hilo_muldiv_sequencer #(
  parameter int DATA_W    = 32,
  parameter bit DIV0_HOLD = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  hilo_muldiv_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t                state_q;
  logic [2*DATA_W-1:0]   acc_q;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0]     opnd_q;    // multiplicand or divisor magnitude
  logic [CNT_W-1:0]      cnt_q;
  logic                  is_div_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  signed_op;
  logic                  sa;
  logic                  sb;
  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       div_shift;
  logic [DATA_W:0]       div_trial;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  assign signed_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign sa        = signed_op & bus.op_a[DATA_W-1];
  assign sb        = signed_op & bus.op_b[DATA_W-1];
  assign mag_a     = sa ? -bus.op_a : bus.op_a;
  assign mag_b     = sb ? -bus.op_b : bus.op_b;

  // Add the multiplicand into the upper half when the multiplier LSB is set;
  // the carry becomes the new top bit after the right shift.
  assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Bring the next dividend bit into the remainder; a clear MSB of the trial
  // difference means the divisor fit.
  assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (bus.start) begin
            case (bus.funct)
              F_MTHI: begin
                hi_q    <= bus.op_a;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              F_MTLO: begin
                lo_q    <= bus.op_a;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              F_MULT, F_MULTU: begin
                acc_q     <= {{DATA_W{1'b0}}, mag_b};
                opnd_q    <= mag_a;
                cnt_q     <= '0;
                is_div_q  <= 1'b0;
                neg_res_q <= sa ^ sb;
                neg_rem_q <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= S_MUL;
              end
              F_DIV, F_DIVU: begin
                if (bus.op_b == '0) begin
                  if (!DIV0_HOLD) begin
                    hi_q <= bus.op_a;
                    lo_q <= '1;
                  end
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  acc_q     <= {{DATA_W{1'b0}}, mag_a};
                  opnd_q    <= mag_b;
                  cnt_q     <= '0;
                  is_div_q  <= 1'b1;
                  neg_res_q <= sa ^ sb;
                  neg_rem_q <= sa;
                  busy_q    <= 1'b1;
                  state_q   <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= {mul_sum, acc_q[DATA_W-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIXUP;
        end
        S_DIV: begin
          if (!div_trial[DATA_W])
            acc_q <= {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
          else
            acc_q <= {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
module tb_hilo_muldiv_sequencer;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   done_cnt;
  int   done_cyc;
  int   busy_total;
  logic [63:0] exp_q[$];

  hilo_muldiv_sequencer_if #(.DATA_W(32)) bus();

  hilo_muldiv_sequencer #(.DATA_W(32), .DIV0_HOLD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: pops one expected {hi,lo} per done pulse.
  initial begin
    logic [63:0] e;
    done_cnt   = 0;
    busy_total = 0;
    done_cyc   = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_total++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
          chk("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic pulse(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int c0, output int prev, output int bsnap);
    @(negedge clk);
    prev      = done_cnt;
    bsnap     = busy_total;
    bus.start = 1'b1;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    c0        = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string nm);
    for (int i = 0; i < 80; i++) begin
      if (done_cnt != prev) break;
      @(posedge clk);
    end
    chk(nm, 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic run(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int lat, input int bz);
    int c0, prev, bsnap;
    exp_q.push_back({eh, el});
    pulse(f, a, b, c0, prev, bsnap);
    wait_done(prev, {nm, "_done"});
    chk({nm, "_latency"}, 64'(done_cyc - c0), 64'(lat));
    chk({nm, "_busy_cycles"}, 64'(busy_total - bsnap), 64'(bz));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, prev, bsnap;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.funct = 6'h00;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   {32'd0, bus.hi}, 64'd0);
    chk("rst_lo",   {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 33);
    run("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34, 33);
    run("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
    run("divu",      F_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        34, 33);
    run("div_wrap",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34, 33);

    run("mthi",      F_MTHI,  32'h11, 32'h0, 32'h11, 32'h80000000, 1, 0);
    run("mtlo",      F_MTLO,  32'h22, 32'h0, 32'h11, 32'h22,       1, 0);
    run("div0",      F_DIV,   32'h1234, 32'h0, 32'h11, 32'h22,     1, 0);

    // Unlisted funct: no done pulse, HI/LO untouched.
    pulse(6'h00, 32'hDEAD, 32'h1, c0, prev, bsnap);
    repeat (5) @(negedge clk);
    chk("bad_funct_no_done", 64'(done_cnt), 64'(prev));
    chk("bad_funct_hi", {32'd0, bus.hi}, 64'h11);
    chk("bad_funct_lo", {32'd0, bus.lo}, 64'h22);

    // MTHI issued while the multiply is busy must be ignored.
    exp_q.push_back({32'd0, 32'hF});
    pulse(F_MULTU, 32'd3, 32'd5, c0, prev, bsnap);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_MTHI;
    bus.op_a  = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(prev, "busy_ignore_done");
    chk("busy_ignore_latency", 64'(done_cyc - c0), 64'd34);
    repeat (5) @(negedge clk);
    chk("busy_ignore_single_done", 64'(done_cnt), 64'(prev + 1));
    chk("busy_ignore_hi", {32'd0, bus.hi}, 64'd0);

    // Reset in the middle of a MULT aborts it without a commit.
    pulse(F_MULT, 32'd5, 32'd6, c0, prev, bsnap);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hi",   {32'd0, bus.hi}, 64'd0);
    chk("abort_lo",   {32'd0, bus.lo}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(prev));
    chk("abort_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_lo_after", {32'd0, bus.lo}, 64'd0);

    run("multu_after_rst", F_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 34, 33);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
